// File: rtl/i2s_transmitter.sv
// Mono 16-bit I2S transmitter: valid/ready sample FIFO, bclk/lrclk derived from clk,
// each word sent MSB-first on both channels with the standard one-bit delay.
module i2s_transmitter #(
  parameter int WIDTH      = 16,
  parameter int BCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic                          bclk,
  output logic                          lrclk,
  output logic                          sdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(BCLK_DIV);

  logic [DW-1:0]    r_div_cnt;
  logic             r_bclk;
  logic [4:0]       r_bit_cnt;
  logic             r_lrclk;
  logic             r_sdata;
  logic             r_underrun;
  logic [WIDTH-1:0] r_cur;
  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             r_ready;

  logic             w_div_wrap;
  logic             w_tick;
  logic [4:0]       w_next_bit;
  logic             w_fetch;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [LW-1:0]    w_next_level;
  logic [WIDTH-1:0] w_next_cur;
  logic [3:0]       w_bit_idx;
  logic             w_next_sdata;

  assign w_div_wrap = (r_div_cnt == DW'(BCLK_DIV - 1));
  assign w_tick     = w_div_wrap && r_bclk;
  assign w_next_bit = r_bit_cnt + 5'd1;
  assign w_fetch    = w_tick && (w_next_bit == 5'd0);
  assign w_empty    = (r_level == '0);
  assign w_push     = sample_valid && r_ready;
  assign w_pop      = w_fetch && !w_empty;
  assign w_next_cur = w_pop ? r_mem[r_rptr] : r_cur;

  // Bit b of the frame carries W[(16-b) mod 16]; b=0 instead takes the
  // previous word's LSB, which is still in r_cur on the fetch edge.
  assign w_bit_idx = 4'd0 - w_next_bit[3:0];

  always_comb begin
    w_next_sdata = w_next_cur[w_bit_idx];
    if (w_next_bit == 5'd0) w_next_sdata = r_cur[0];
  end

  always_comb begin
    w_next_level = r_level;
    if (w_push && !w_pop)      w_next_level = r_level + LW'(1);
    else if (!w_push && w_pop) w_next_level = r_level - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt  <= '0;
      r_bclk     <= 1'b0;
      r_bit_cnt  <= '1;
      r_lrclk    <= 1'b1;
      r_sdata    <= 1'b0;
      r_underrun <= 1'b0;
      r_cur      <= '0;
    end else begin
      r_div_cnt  <= w_div_wrap ? '0 : r_div_cnt + DW'(1);
      r_underrun <= w_fetch && w_empty;
      if (w_div_wrap) r_bclk <= !r_bclk;
      if (w_tick) begin
        r_bit_cnt <= w_next_bit;
        r_lrclk   <= w_next_bit[4];
        r_sdata   <= w_next_sdata;
        r_cur     <= w_next_cur;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ready <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_level <= w_next_level;
      r_ready <= (w_next_level != LW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= sample_in;
  end

  assign sample_ready = r_ready;
  assign bclk         = r_bclk;
  assign lrclk        = r_lrclk;
  assign sdata        = r_sdata;
  assign fifo_level   = r_level;
  assign underrun     = r_underrun;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: edge-count arithmetic model checked every cycle,
// plus directed scenarios with hand-computed frame bit patterns.
module tb_i2s_transmitter;

  localparam int D     = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic [2:0]  fifo_level;
  logic        underrun;

  always #5 clk = ~clk;

  i2s_transmitter #(.WIDTH(16), .BCLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .fifo_level(fifo_level), .underrun(underrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: state is derived from the number of edges since reset released.
  bit          m_live = 0;
  int          m_n = 0;
  int          m_b = 31;
  int          m_k;
  int          m_frame = 0;
  bit          m_tick = 0;
  logic [15:0] m_cur = '0;
  logic [15:0] m_prev = '0;
  logic [15:0] q[$];
  bit          m_bclk = 0, m_lr = 1, m_sd = 0, m_und = 0;
  bit          m_push;

  always @(posedge clk) begin
    if (reset) begin
      m_live = 1; m_n = 0; m_b = 31; m_frame = 0; m_tick = 0;
      m_cur = '0; m_prev = '0; q.delete();
      m_bclk = 0; m_lr = 1; m_sd = 0; m_und = 0;
    end else if (m_live) begin
      m_n++;
      m_und  = 0;
      m_tick = 0;
      m_push = sample_valid && (q.size() < DEPTH);
      if (m_n % (2 * D) == 0) begin
        m_tick  = 1;
        m_k     = m_n / (2 * D);
        m_b     = (m_k - 1) % 32;
        m_frame = (m_k - 1) / 32;
        if (m_b == 0) begin
          m_prev = m_cur;
          if (q.size() > 0) m_cur = q.pop_front();
          else m_und = 1;
        end
        if (m_b == 0)       m_sd = m_prev[0];
        else if (m_b < 16)  m_sd = m_cur[16 - m_b];
        else if (m_b == 16) m_sd = m_cur[0];
        else                m_sd = m_cur[32 - m_b];
      end
      m_bclk = ((m_n / D) % 2) == 1;
      m_lr   = (m_b >= 16);
      if (m_push) q.push_back(sample_in);
    end
  end

  logic [31:0] cap_sd [4];
  logic [31:0] cap_lr [4];
  int          und_cnt = 0;

  always @(negedge clk) begin
    if (m_live) begin
      chk("bclk", 32'(bclk), 32'(m_bclk));
      chk("lrclk", 32'(lrclk), 32'(m_lr));
      chk("sdata", 32'(sdata), 32'(m_sd));
      chk("underrun", 32'(underrun), 32'(m_und));
      chk("fifo_level", 32'(fifo_level), 32'(q.size()));
      chk("sample_ready", 32'(sample_ready), 32'(q.size() < DEPTH));
      if (m_tick && m_frame < 4) begin
        cap_sd[m_frame][31 - m_b] = sdata;
        cap_lr[m_frame][31 - m_b] = lrclk;
      end
      if (underrun === 1'b1) und_cnt++;
    end
  end

  task automatic wait_edge(input int e);
    int g = 0;
    while (m_n < e && g < 20000) begin
      @(negedge clk);
      g++;
    end
    chk("wait_edge", 32'(m_n), 32'(e));
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_bclk"}, 32'(bclk), 32'd0);
    chk({nm, "_lrclk"}, 32'(lrclk), 32'd1);
    chk({nm, "_sdata"}, 32'(sdata), 32'd0);
    chk({nm, "_ready"}, 32'(sample_ready), 32'd1);
    chk({nm, "_level"}, 32'(fifo_level), 32'd0);
    chk({nm, "_underrun"}, 32'(underrun), 32'd0);
  endtask

  task automatic clear_caps();
    for (int i = 0; i < 4; i++) begin
      cap_sd[i] = '0;
      cap_lr[i] = '0;
    end
    und_cnt = 0;
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    clear_caps();
    reset = 1'b0;
  endtask

  initial begin
    int w;
    bit rdy;

    // Reset and first bclk fall
    do_reset();
    wait_edge(7);
    chk("first_bclk_high_e7", 32'(bclk), 32'd1);
    wait_edge(8);
    chk("first_bclk_fall_e8", 32'(bclk), 32'd0);
    chk("first_lrclk_e8", 32'(lrclk), 32'd0);

    // Single word 0xA5C3
    do_reset();
    sample_valid = 1'b1; sample_in = 16'hA5C3;
    wait_edge(1);
    sample_valid = 1'b0;
    chk("single_level_e1", 32'(fifo_level), 32'd1);
    wait_edge(8);
    chk("single_level_e8", 32'(fifo_level), 32'd0);
    chk("single_underrun_e8", 32'(underrun), 32'd0);
    wait_edge(257);
    chk("single_sdata_frame", cap_sd[0], 32'h52E1D2E1);
    chk("single_lrclk_frame", cap_lr[0], 32'h0000FFFF);

    // Fill with words 1..5
    do_reset();
    w = 1;
    for (int g = 0; g < 40 && w <= 5; g++) begin
      sample_in = 16'(w);
      sample_valid = 1'b1;
      rdy = sample_ready;
      @(negedge clk);
      if (rdy) w++;
      if (m_n == 4) begin
        chk("fill_level_e4", 32'(fifo_level), 32'd4);
        chk("fill_ready_e4", 32'(sample_ready), 32'd0);
      end
      if (m_n == 8) begin
        chk("fill_level_e8", 32'(fifo_level), 32'd3);
        chk("fill_ready_e8", 32'(sample_ready), 32'd1);
      end
    end
    sample_valid = 1'b0;
    chk("fill_word5_edge", 32'(m_n), 32'd9);
    chk("fill_level_e9", 32'(fifo_level), 32'd4);
    wait_edge(257);
    chk("fill_frame0", cap_sd[0], 32'h00008000);

    // Underrun repeats the last word
    do_reset();
    sample_valid = 1'b1; sample_in = 16'h8001;
    wait_edge(1);
    sample_valid = 1'b0;
    wait_edge(263);
    chk("und_none_before", 32'(und_cnt), 32'd0);
    wait_edge(264);
    chk("und_pulse_e264", 32'(underrun), 32'd1);
    wait_edge(265);
    chk("und_clear_e265", 32'(underrun), 32'd0);
    wait_edge(519);
    chk("und_count", 32'(und_cnt), 32'd1);
    chk("und_frame0", cap_sd[0], 32'h4000C000);
    chk("und_frame1", cap_sd[1], 32'hC000C000);

    // Push on the fetch edge with the FIFO empty
    do_reset();
    wait_edge(7);
    sample_valid = 1'b1; sample_in = 16'h1234;
    wait_edge(8);
    sample_valid = 1'b0;
    chk("coin_underrun_e8", 32'(underrun), 32'd1);
    chk("coin_level_e8", 32'(fifo_level), 32'd1);
    wait_edge(9);
    chk("coin_underrun_e9", 32'(underrun), 32'd0);
    wait_edge(264);
    chk("coin_level_e264", 32'(fifo_level), 32'd0);
    chk("coin_underrun_e264", 32'(underrun), 32'd0);
    wait_edge(513);
    chk("coin_frame0", cap_sd[0], 32'h00000000);
    chk("coin_frame1", cap_sd[1], 32'h091A091A);

    // Reset mid-frame
    do_reset();
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1;
      sample_in = 16'h1111 * 16'(i + 1);
      @(negedge clk);
    end
    sample_valid = 1'b0;
    wait_edge(8);
    chk("mid_level_e8", 32'(fifo_level), 32'd2);
    wait_edge(168);
    chk("mid_level_b20", 32'(fifo_level), 32'd2);
    chk("mid_lrclk_b20", 32'(lrclk), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("mid");
    clear_caps();
    reset = 1'b0;
    wait_edge(8);
    chk("mid_restart_underrun", 32'(underrun), 32'd1);
    chk("mid_restart_sdata", 32'(sdata), 32'd0);
    chk("mid_restart_level", 32'(fifo_level), 32'd0);
    wait_edge(257);
    chk("mid_restart_frame0", cap_sd[0], 32'h00000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/i2s_transmitter.md
# i2s_transmitter

Serializes the processed 16-bit audio stream leaving the DSP subsystem into an I2S bit stream for the DAC. It accepts samples over a valid/ready handshake into a small FIFO, generates bclk and lrclk by dividing the single system clock, and shifts each word out MSB-first. Each word is sent on both left and right channels, because the DSP path is mono. It is the output-side counterpart of the sample-in path and sits between the DSP subsystem output and the codec pins.

## Interface
- WIDTH, 16, sample width in bits; the frame format below is fixed for 16.
- BCLK_DIV, 4, clk cycles per bclk half-period; must be ≥2.
- FIFO_DEPTH, 4, sample FIFO entries; must be a power of 2.
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- sample_in  input  WIDTH  sample word, two's complement.
- sample_valid  input  1  sample_in is valid this cycle.
- sample_ready  output  1  FIFO can accept a word; equals !full.
- bclk  output  1  I2S bit clock.
- lrclk  output  1  word select; 0 = left channel, 1 = right channel.
- sdata  output  1  serial data, MSB-first; changes on the falling edge of bclk.
- fifo_level  output  log2(FIFO_DEPTH)+1  number of words currently in the FIFO.
- underrun  output  1  one-cycle pulse when a frame starts with the FIFO empty.

## Operation
- **Push.** A word is pushed when sample_valid && sample_ready. Words pushed while ready=0 are ignored, and the upstream holds them.
- **Divider.** div_cnt counts 0..BCLK_DIV-1. When div_cnt == BCLK_DIV-1, div_cnt wraps to 0 and bclk toggles.
- **Bit tick.** A toggle that takes bclk from 1 to 0 is a "bit tick".
- **Bit counter.** bit_cnt (5 bits) increments, mod 32, on every bit tick.
- **lrclk.** lrclk = bit_cnt[4], registered alongside bit_cnt.
- **Frame fetch.** At the bit tick where bit_cnt wraps 31→0, cur_word is fetched:
  - FIFO non-empty: pop the head into cur_word.
  - FIFO empty: cur_word keeps its previous value and underrun pulses in that cycle.
  - Each popped word is transmitted in exactly one frame.
- **sdata mapping** for the frame carrying word W (prev = W of the previous frame):
  - b=0: prev[0].
  - b=1..15: W[16-b].
  - b=16: W[0].
  - b=17..31: W[32-b].
  - This gives the standard I2S one-bit delay, with lrclk switching during the LSB of the previous channel.
- **Simultaneous push and fetch, FIFO empty.** The fetch sees empty: underrun pulses and the old word repeats. The push lands, giving level=1.
- **Simultaneous push and fetch, FIFO neither empty nor full.** Both happen and the level is unchanged.
- **FIFO full.** ready=0, so no push. A fetch in that cycle pops, and ready returns to 1 the next cycle.
- **Pointer wrap.** Read and write pointers wrap modulo FIFO_DEPTH. An extra level bit distinguishes full from empty.

## Timing
- **Reset values:** bclk=0, lrclk=1, sdata=0, sample_ready=1, fifo_level=0, underrun=0. Internally div_cnt=0, bit_cnt=31, cur_word=0, prev word=0, and the FIFO is flushed.
- **First frame start.** The first bit tick occurs on the 2·BCLK_DIV-th clk edge after reset deasserts (edge 8 with defaults). bit_cnt becomes 0 and the first fetch happens there.
- **Output registration.** All outputs are registered. sdata and lrclk update on the same edge on which bclk falls.
- **Frame period.** 64·BCLK_DIV clk cycles (256 with defaults), with 32 bclk periods per frame.
- **Push latency.** A word pushed at least one cycle before a frame fetch is sent in that frame. Its MSB appears at b=1, one bclk period after the fetch.
- **FIFO status timing.** sample_ready and fifo_level reflect the pushes and pops of the previous edge.
- **Reset during a frame.** Reset asserted at any cycle forces every output to its reset value on that edge and discards the partial frame and the FIFO contents. Operation restarts exactly as after power-on reset.

## Test plan
- **Reset.** Hold reset 3 cycles, then release → bclk=0, lrclk=1, sdata=0, ready=1, level=0, underrun=0. The first bclk fall is at edge 8 after release.
- **Single word.** Push 0xA5C3 at cycle 1 → fetch at edge 8 with level 1→0 and no underrun.
  - sdata over b=0..31 is 0, then bits 15..1 of A5C3, then 1, then bits 15..1 of A5C3.
  - lrclk is 0 for b=0..15 and 1 for b=16..31.
- **Fill.** Hold valid with words 1..5 from reset → ready drops after 4 accepts and level=4. At the next fetch level=3 and ready=1, and word 5 is then accepted.
- **Underrun.** Push 0x8001, then push nothing → frame 1 sends 0x8001. The second fetch pulses underrun for exactly 1 cycle, frame 2 resends 0x8001, and b=0 of frame 2 carries 1.
- **Push coinciding with a fetch.** Assert valid on exactly the fetch edge with the FIFO empty → underrun pulses, level becomes 1, and the word is sent in the following frame.
- **Reset mid-frame.** Assert reset at bit_cnt=20 while level=2 → all outputs are at reset values on the next edge and level=0. The stream restarts at edge 8 after release with an underrun pulse (FIFO empty) and prev word = 0.
